// File: rtl/pal_array.sv
// PAL core: programmable AND plane, programmable OR plane and per-output macrocell,
// configured through a serial bitstream loaded one bit per valid cycle.
module pal_array #(
    parameter int unsigned N_IN    = 4,
    parameter int unsigned N_TERMS = 4,
    parameter int unsigned N_OUT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic              cfg_valid,
    input  logic              cfg_data,
    output logic              cfg_busy,
    output logic              cfg_done,
    input  logic [N_IN-1:0]   pal_in,
    output logic [N_OUT-1:0]  pal_out
);

    localparam int unsigned LIT_W   = 2 * N_IN;
    localparam int unsigned A_LEN   = N_TERMS * LIT_W;
    localparam int unsigned O_LEN   = N_OUT * N_TERMS;
    localparam int unsigned M_BASE  = A_LEN + O_LEN;
    localparam int unsigned CFG_LEN = M_BASE + 2 * N_OUT;
    localparam int unsigned CNT_W   = $clog2(CFG_LEN);

    typedef enum logic [1:0] {ST_UNCFG, ST_LOAD, ST_RUN} state_t;

    state_t               state, state_next;
    logic [CFG_LEN-1:0]   cfg;
    logic [CNT_W-1:0]     cnt;
    logic [N_OUT-1:0]     flop;
    logic [LIT_W-1:0]     lits;
    logic [N_TERMS-1:0]   term;
    logic [N_OUT-1:0]     f;
    logic                 last_bit;

    // Literal vector: even index is the true input, odd index its complement.
    always_comb begin
        lits = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            lits[2*i]   = pal_in[i];
            lits[2*i+1] = ~pal_in[i];
        end
    end

    // Unselected literals are forced to 1 and unselected terms to 0 (neutral elements).
    always_comb begin
        term = '0;
        f    = '0;
        for (int unsigned t = 0; t < N_TERMS; t++)
            term[t] = &(lits | ~cfg[t*LIT_W +: LIT_W]);
        for (int unsigned o = 0; o < N_OUT; o++)
            f[o] = (|(term & cfg[A_LEN + o*N_TERMS +: N_TERMS])) ^ cfg[M_BASE + 2*o];
    end

    assign last_bit = cfg_valid && (cnt == CNT_W'(CFG_LEN - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_UNCFG;
        else     state <= state_next;
    end

    // Next-state logic; cfg_start takes priority over any bit in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_UNCFG: if (cfg_start) state_next = ST_LOAD;
            ST_LOAD: begin
                if (cfg_start)     state_next = ST_LOAD;
                else if (last_bit) state_next = ST_RUN;
            end
            ST_RUN:   if (cfg_start) state_next = ST_LOAD;
            default:  state_next = ST_UNCFG;
        endcase
    end

    // Configuration shift-in, bit counter and macrocell flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg  <= '0;
            cnt  <= '0;
            flop <= '0;
        end else if (cfg_start) begin
            cfg  <= '0;
            cnt  <= '0;
            flop <= '0;
        end else begin
            if (state == ST_LOAD && cfg_valid) begin
                cfg[cnt] <= cfg_data;
                cnt      <= cnt + CNT_W'(1);
            end
            if (state == ST_RUN) flop <= f;
            else                 flop <= '0;
        end
    end

    // Outputs: array is only visible while a complete configuration is held.
    always_comb begin
        cfg_busy = (state == ST_LOAD);
        cfg_done = (state == ST_RUN);
        pal_out  = '0;
        if (state == ST_RUN) begin
            for (int unsigned o = 0; o < N_OUT; o++)
                pal_out[o] = cfg[M_BASE + 2*o + 1] ? flop[o] : f[o];
        end
    end

endmodule

// File: tb/tb_pal_array.sv
// Self-checking bench for pal_array: table-driven combinational vectors plus
// hand-written sequences for registered mode, reset mid-load and restart.
module tb_pal_array;

    localparam int unsigned CFG_LEN = 44;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_start, cfg_valid, cfg_data;
    logic       cfg_busy, cfg_done;
    logic [3:0] pal_in;
    logic [1:0] pal_out;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [CFG_LEN-1:0] cfg;
        logic [3:0]         in;
        logic [1:0]         exp;
    } vec_t;

    vec_t tbl[$];

    pal_array dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_start(cfg_start),
        .cfg_valid(cfg_valid),
        .cfg_data (cfg_data),
        .cfg_busy (cfg_busy),
        .cfg_done (cfg_done),
        .pal_in   (pal_in),
        .pal_out  (pal_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [CFG_LEN-1:0] mk(input int a, input int b, input int c);
        logic [CFG_LEN-1:0] r;
        r = '0;
        if (a >= 0) r[a] = 1'b1;
        if (b >= 0) r[b] = 1'b1;
        if (c >= 0) r[c] = 1'b1;
        return r;
    endfunction

    // Full load: start pulse (optionally with a stray valid bit), then 44 bits.
    task automatic load(input logic [CFG_LEN-1:0] bits, input bit gaps, input bit stray);
        @(negedge clk);
        cfg_start = 1'b1;
        cfg_valid = stray;
        cfg_data  = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        #1;
        chk("load_busy", 32'(cfg_busy), 32'd1);
        chk("load_done_low", 32'(cfg_done), 32'd0);
        chk("load_out_zero", 32'(pal_out), 32'd0);
        for (int k = 0; k < CFG_LEN; k++) begin
            if (gaps) begin
                int n;
                n = $urandom_range(0, 2);
                cfg_valid = 1'b0;
                repeat (n) @(negedge clk);
            end
            cfg_valid = 1'b1;
            cfg_data  = bits[k];
            if (k == CFG_LEN - 1) begin
                #1 chk("done_before_last_edge", 32'(cfg_done), 32'd0);
            end
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        cfg_data  = 1'b0;
        #1;
        chk("done_after_last_bit", 32'(cfg_done), 32'd1);
        chk("busy_after_last_bit", 32'(cfg_busy), 32'd0);
    endtask

    task automatic apply(input string nm, input logic [3:0] in, input logic [1:0] exp);
        @(negedge clk);
        pal_in = in;
        #1 chk(nm, 32'(pal_out), 32'(exp));
    endtask

    logic [CFG_LEN-1:0] cfg_a, cfg_p, cfg_z, cfg_r, cur;
    bit                 loaded;

    initial begin
        cfg_a = mk(0, 2, 32);     // out0 = in0 & in1
        cfg_p = mk(40, -1, -1);   // out0 = ~0 = 1
        cfg_z = mk(0, 1, 32);     // out0 = in0 & ~in0 = 0
        cfg_r = mk(13, 37, 43);   // out1 = flop(~in2)

        tbl.push_back('{cfg_a, 4'b0011, 2'b01});
        tbl.push_back('{cfg_a, 4'b0001, 2'b00});
        tbl.push_back('{cfg_a, 4'b0010, 2'b00});
        tbl.push_back('{cfg_a, 4'b1111, 2'b01});
        tbl.push_back('{cfg_a, 4'b0000, 2'b00});
        tbl.push_back('{cfg_a, 4'b1011, 2'b01});
        for (int v = 0; v < 16; v++) tbl.push_back('{cfg_p, 4'(v), 2'b01});
        tbl.push_back('{cfg_z, 4'b0000, 2'b00});
        tbl.push_back('{cfg_z, 4'b0001, 2'b00});
        tbl.push_back('{cfg_z, 4'b1111, 2'b00});
        tbl.push_back('{cfg_z, 4'b1110, 2'b00});

        // T1: reset holds everything at zero regardless of pal_in
        rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = 1'b0; pal_in = 4'b0000;
        for (int v = 0; v < 4; v++) begin
            pal_in = 4'(v * 5);
            #3;
            chk("rst_out", 32'(pal_out), 32'd0);
            chk("rst_busy", 32'(cfg_busy), 32'd0);
            chk("rst_done", 32'(cfg_done), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1 chk("idle_done", 32'(cfg_done), 32'd0);

        // T2/T4: table of combinational vectors, reloading when the config changes
        loaded = 1'b0;
        cur    = '0;
        foreach (tbl[i]) begin
            if (!loaded || tbl[i].cfg !== cur) begin
                load(tbl[i].cfg, 1'b0, 1'b0);
                cur    = tbl[i].cfg;
                loaded = 1'b1;
            end
            apply($sformatf("vec%0d_in%b", i, tbl[i].in), tbl[i].in, tbl[i].exp);
        end

        // T3: registered output one cycle behind ~in2
        pal_in = 4'b0000;
        load(cfg_r, 1'b0, 1'b0);
        chk("reg_first_run_cycle", 32'(pal_out), 32'd0);
        @(negedge clk);
        #1 chk("reg_captured_one", 32'(pal_out), 32'b10);
        pal_in = 4'b0100;
        #1 chk("reg_holds_before_edge", 32'(pal_out), 32'b10);
        @(negedge clk);
        #1 chk("reg_falls_after_edge", 32'(pal_out), 32'b00);
        pal_in = 4'b0000;
        @(negedge clk);
        #1 chk("reg_rises_again", 32'(pal_out), 32'b10);

        // T6: stray bits in RUN leave the configuration unchanged
        cfg_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cfg_data = k[0];
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        #1;
        chk("stray_done", 32'(cfg_done), 32'd1);
        chk("stray_out_in0000", 32'(pal_out), 32'b10);
        pal_in = 4'b0100;
        @(negedge clk);
        #1 chk("stray_out_in0100", 32'(pal_out), 32'b00);

        // T6: restart from RUN with a simultaneous valid bit that must be dropped
        load(cfg_a, 1'b0, 1'b1);
        apply("restart_in0011", 4'b0011, 2'b01);
        apply("restart_in0001", 4'b0001, 2'b00);

        // Restart in LOAD: partial ones then a fresh load
        @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_valid = 1'b1;
        cfg_data  = 1'b1;
        repeat (10) @(negedge clk);
        cfg_valid = 1'b0;
        load(cfg_z, 1'b1, 1'b0);
        apply("reload_z_in1111", 4'b1111, 2'b00);

        // T5: reset during a gapped load loses the partial configuration
        pal_in = 4'b0011;
        @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            int n;
            n = $urandom_range(0, 2);
            cfg_valid = 1'b0;
            repeat (n) @(negedge clk);
            cfg_valid = 1'b1;
            cfg_data  = cfg_a[k];
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midload_rst_busy", 32'(cfg_busy), 32'd0);
        chk("midload_rst_done", 32'(cfg_done), 32'd0);
        chk("midload_rst_out", 32'(pal_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("after_rst_done", 32'(cfg_done), 32'd0);
        chk("after_rst_out", 32'(pal_out), 32'd0);
        load(cfg_a, 1'b1, 1'b0);
        apply("gapped_in0011", 4'b0011, 2'b01);
        apply("gapped_in0001", 4'b0001, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
